icache_port_arbiter: RTL and testbench

ICACHE_PORT_ARBITER -- requirements
Module: icache_port_arbiter

---
 rtl/icache_port_arbiter_if.sv | 51 +++++
 rtl/icache_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_icache_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_port_arbiter_if.sv
// Request/response bundle between the fetch unit, the CACHE-instruction
// unit, the ICache array and the port arbiter.
interface icache_port_arbiter_if;
  logic        f_req_valid;
  logic [7:0]  f_index;
  logic [19:0] f_tag;
  logic [3:0]  f_offset;
  logic        f_grant;

  logic        c_req_valid;
  logic [1:0]  c_op;
  logic [7:0]  c_index;
  logic [19:0] c_tag;
  logic        c_grant;
  logic        c_done;

  logic        redirect;
  logic        f_resp_valid;
  logic        f_resp_discard;

  logic        ic_valid;
  logic [1:0]  ic_op;
  logic [7:0]  ic_index;
  logic [19:0] ic_tag;
  logic [3:0]  ic_offset;
  logic        ic_busy;
  logic        ic_resp_valid;

  logic        arb_busy;
  logic        wdog_err;

  // Arbiter view
  modport slave (
    input  f_req_valid, f_index, f_tag, f_offset,
    input  c_req_valid, c_op, c_index, c_tag,
    input  redirect, ic_busy, ic_resp_valid,
    output f_grant, c_grant, c_done, f_resp_valid, f_resp_discard,
    output ic_valid, ic_op, ic_index, ic_tag, ic_offset,
    output arb_busy, wdog_err
  );

  // Requester / ICache view
  modport master (
    output f_req_valid, f_index, f_tag, f_offset,
    output c_req_valid, c_op, c_index, c_tag,
    output redirect, ic_busy, ic_resp_valid,
    input  f_grant, c_grant, c_done, f_resp_valid, f_resp_discard,
    input  ic_valid, ic_op, ic_index, ic_tag, ic_offset,
    input  arb_busy, wdog_err
  );
endinterface

// File: rtl/icache_port_arbiter.sv
// Arbitrates the single ICache port between instruction fetch and CACHE
// instructions. One transaction outstanding; cache ops win unless a fetch
// has been starved for STARVE_MAX consecutive cache-op grants.
//
//   state       | meaning
//   S_IDLE      | no transaction; latch a request if one is eligible
//   S_REQ       | ic_valid asserted with held payload until ~ic_busy
//   S_WAIT_RESP | accepted; waiting for ic_resp_valid or watchdog expiry
module icache_port_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int WDOG_MAX   = 255
) (
  input logic clk,
  input logic reset,
  icache_port_arbiter_if.slave bus
);

  localparam int SW = (STARVE_MAX < 4) ? 2 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [7:0]    WDOG_LAST  = 8'(WDOG_MAX - 1);
  localparam logic [1:0]    OP_FETCH   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_fetch_q, owner_fetch_d;
  logic          kill_q, kill_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [7:0]    wdog_q, wdog_d;
  logic [1:0]    op_q, op_d;
  logic [7:0]    index_q, index_d;
  logic [19:0]   tag_q, tag_d;
  logic [3:0]    offset_q, offset_d;

  logic fetch_ok, cop_ok, fetch_wins, in_req;

  // State, bookkeeping and payload registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      owner_fetch_q <= 1'b0;
      kill_q        <= 1'b0;
      starve_q      <= '0;
      wdog_q        <= '0;
      op_q          <= '0;
      index_q       <= '0;
      tag_q         <= '0;
      offset_q      <= '0;
    end else begin
      state_q       <= state_d;
      owner_fetch_q <= owner_fetch_d;
      kill_q        <= kill_d;
      starve_q      <= starve_d;
      wdog_q        <= wdog_d;
      op_q          <= op_d;
      index_q       <= index_d;
      tag_q         <= tag_d;
      offset_q      <= offset_d;
    end
  end

  // Next-state, arbitration and output decode
  always_comb begin
    state_d       = state_q;
    owner_fetch_d = owner_fetch_q;
    kill_d        = kill_q;
    starve_d      = starve_q;
    wdog_d        = wdog_q;
    op_d          = op_q;
    index_d       = index_q;
    tag_d         = tag_q;
    offset_d      = offset_q;

    bus.f_grant        = 1'b0;
    bus.c_grant        = 1'b0;
    bus.c_done         = 1'b0;
    bus.f_resp_valid   = 1'b0;
    bus.f_resp_discard = 1'b0;
    bus.wdog_err       = 1'b0;

    // grants are gated by reset so every output is quiet while it is held
    fetch_ok   = bus.f_req_valid & ~bus.redirect & reset;
    cop_ok     = bus.c_req_valid & reset;
    fetch_wins = fetch_ok & ((starve_q == STARVE_TOP) | ~cop_ok);
    in_req     = (state_q == S_REQ);

    case (state_q)
      S_IDLE: begin
        if (fetch_wins) begin
          bus.f_grant   = 1'b1;
          owner_fetch_d = 1'b1;
          op_d          = OP_FETCH;
          index_d       = bus.f_index;
          tag_d         = bus.f_tag;
          offset_d      = bus.f_offset;
          starve_d      = '0;
          state_d       = S_REQ;
        end else if (cop_ok) begin
          bus.c_grant   = 1'b1;
          owner_fetch_d = 1'b0;
          op_d          = bus.c_op;
          index_d       = bus.c_index;
          tag_d         = bus.c_tag;
          offset_d      = '0;
          state_d       = S_REQ;
          if (!bus.f_req_valid)
            starve_d = '0;
          else if (starve_q != STARVE_TOP)
            starve_d = starve_q + 1'b1;
        end else if (!bus.f_req_valid) begin
          starve_d = '0;
        end
      end

      S_REQ: begin
        if (bus.redirect && owner_fetch_q) kill_d = 1'b1;
        if (!bus.ic_busy) begin
          wdog_d  = '0;
          state_d = S_WAIT_RESP;
        end
      end

      S_WAIT_RESP: begin
        if (bus.redirect && owner_fetch_q) kill_d = 1'b1;
        if (bus.ic_resp_valid) begin
          if (!owner_fetch_q)
            bus.c_done = 1'b1;
          else if (kill_q || bus.redirect)
            bus.f_resp_discard = 1'b1;
          else
            bus.f_resp_valid = 1'b1;
          kill_d  = 1'b0;
          state_d = S_IDLE;
        end else if (wdog_q == WDOG_LAST) begin
          bus.wdog_err       = 1'b1;
          bus.c_done         = ~owner_fetch_q;
          bus.f_resp_discard = owner_fetch_q;
          kill_d             = 1'b0;
          state_d            = S_IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    bus.ic_valid  = in_req;
    bus.ic_op     = in_req ? op_q     : 2'b00;
    bus.ic_index  = in_req ? index_q  : 8'h00;
    bus.ic_tag    = in_req ? tag_q    : 20'h0;
    bus.ic_offset = in_req ? offset_q : 4'h0;
    bus.arb_busy  = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_icache_port_arbiter.sv
module tb_icache_port_arbiter;
  localparam int STARVE_MAX = 3;
  localparam int WDOG_MAX   = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  icache_port_arbiter_if bus();

  icache_port_arbiter #(.STARVE_MAX(STARVE_MAX), .WDOG_MAX(WDOG_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: one outstanding transaction described by flags
  bit          m_busy, m_fetch, m_acc, m_kill;
  int          m_wait, m_starve;
  logic [1:0]  m_op;
  logic [7:0]  m_index;
  logic [19:0] m_tag;
  logic [3:0]  m_offset;

  logic        e_fg, e_cg, e_cd, e_rv, e_rd, e_icv, e_busy, e_werr;
  logic [1:0]  e_op;
  logic [7:0]  e_idx;
  logic [19:0] e_tag;
  logic [3:0]  e_off;
  bit          take_f, take_c, finish_txn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy = 0; m_fetch = 0; m_acc = 0; m_kill = 0;
    m_wait = 0; m_starve = 0;
    m_op = '0; m_index = '0; m_tag = '0; m_offset = '0;
  endfunction

  function automatic void model_eval();
    {e_fg, e_cg, e_cd, e_rv, e_rd, e_icv, e_werr} = '0;
    e_op = '0; e_idx = '0; e_tag = '0; e_off = '0;
    take_f = 0; take_c = 0; finish_txn = 0;
    e_busy = m_busy;
    if (!m_busy) begin
      take_f = bus.f_req_valid && !bus.redirect &&
               (m_starve >= STARVE_MAX || !bus.c_req_valid);
      take_c = !take_f && bus.c_req_valid;
      e_fg = take_f;
      e_cg = take_c;
    end else if (!m_acc) begin
      e_icv = 1'b1;
      e_op  = m_fetch ? 2'b11 : m_op;
      e_idx = m_index;
      e_tag = m_tag;
      e_off = m_offset;
    end else if (bus.ic_resp_valid) begin
      finish_txn = 1;
      if (!m_fetch) e_cd = 1'b1;
      else if (m_kill || bus.redirect) e_rd = 1'b1;
      else e_rv = 1'b1;
    end else if (m_wait == WDOG_MAX - 1) begin
      finish_txn = 1;
      e_werr = 1'b1;
      if (m_fetch) e_rd = 1'b1; else e_cd = 1'b1;
    end
  endfunction

  function automatic void model_advance();
    if (!m_busy) begin
      if (take_f || take_c) begin
        m_busy = 1; m_acc = 0; m_kill = 0; m_fetch = take_f;
        if (take_f) begin
          m_op = 2'b11; m_index = bus.f_index; m_tag = bus.f_tag; m_offset = bus.f_offset;
        end else begin
          m_op = bus.c_op; m_index = bus.c_index; m_tag = bus.c_tag; m_offset = '0;
        end
      end
      if (take_f || !bus.f_req_valid) m_starve = 0;
      else if (take_c && m_starve < STARVE_MAX) m_starve++;
    end else begin
      if (m_fetch && bus.redirect) m_kill = 1;
      if (!m_acc) begin
        if (!bus.ic_busy) begin m_acc = 1; m_wait = 0; end
      end else if (finish_txn) begin
        m_busy = 0; m_kill = 0;
      end else begin
        m_wait++;
      end
    end
  endfunction

  task automatic sample();
    #4;
    model_eval();
    chk("f_grant",        bus.f_grant,        e_fg);
    chk("c_grant",        bus.c_grant,        e_cg);
    chk("c_done",         bus.c_done,         e_cd);
    chk("f_resp_valid",   bus.f_resp_valid,   e_rv);
    chk("f_resp_discard", bus.f_resp_discard, e_rd);
    chk("ic_valid",       bus.ic_valid,       e_icv);
    chk("ic_op",          bus.ic_op,          e_op);
    chk("ic_index",       bus.ic_index,       e_idx);
    chk("ic_tag",         bus.ic_tag,         e_tag);
    chk("ic_offset",      bus.ic_offset,      e_off);
    chk("arb_busy",       bus.arb_busy,       e_busy);
    chk("wdog_err",       bus.wdog_err,       e_werr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic clear_inputs();
    bus.f_req_valid = 0; bus.f_index = '0; bus.f_tag = '0; bus.f_offset = '0;
    bus.c_req_valid = 0; bus.c_op = '0; bus.c_index = '0; bus.c_tag = '0;
    bus.redirect = 0; bus.ic_busy = 0; bus.ic_resp_valid = 0;
  endtask

  initial begin
    logic [4:0] seq;
    int         ngr, wcnt, wat;

    // reset state, with requests pending to show grants stay quiet
    reset = 1'b0;
    clear_inputs();
    model_reset();
    bus.f_req_valid = 1; bus.c_req_valid = 1;
    #3;
    chk("rst_f_grant",  bus.f_grant,  0);
    chk("rst_c_grant",  bus.c_grant,  0);
    chk("rst_ic_valid", bus.ic_valid, 0);
    chk("rst_arb_busy", bus.arb_busy, 0);
    chk("rst_wdog_err", bus.wdog_err, 0);
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    sample(); tick();

    // fetch only, best-case latency
    bus.f_req_valid = 1; bus.f_index = 8'h3A; bus.f_tag = 20'h12345; bus.f_offset = 4'h7;
    sample(); chk("d1_f_grant", bus.f_grant, 1); tick();
    bus.f_req_valid = 0;
    sample();
    chk("d1_ic_valid", bus.ic_valid, 1);
    chk("d1_ic_op",    bus.ic_op,    2'b11);
    chk("d1_ic_index", bus.ic_index, 8'h3A);
    tick();
    bus.ic_resp_valid = 1;
    sample(); chk("d1_f_resp_valid", bus.f_resp_valid, 1); tick();
    bus.ic_resp_valid = 0;
    sample(); tick();

    // simultaneous requests: cache op first, fetch on the next IDLE cycle
    bus.c_req_valid = 1; bus.c_op = 2'b00; bus.c_index = 8'h11; bus.c_tag = 20'hABCDE;
    bus.f_req_valid = 1; bus.f_index = 8'h22;
    sample(); chk("d2_c_grant", bus.c_grant, 1); chk("d2_f_grant0", bus.f_grant, 0); tick();
    bus.c_req_valid = 0;
    sample(); chk("d2_ic_op", bus.ic_op, 2'b00); tick();
    bus.ic_resp_valid = 1;
    sample(); chk("d2_c_done", bus.c_done, 1); tick();
    bus.ic_resp_valid = 0;
    sample(); chk("d2_f_grant", bus.f_grant, 1); tick();
    bus.f_req_valid = 0;
    sample(); tick();
    bus.ic_resp_valid = 1;
    sample(); tick();
    bus.ic_resp_valid = 0;
    sample(); tick();

    // continuous contention: three cache ops, then the starved fetch
    bus.c_req_valid = 1; bus.c_op = 2'b10; bus.f_req_valid = 1;
    bus.ic_resp_valid = 1;
    seq = '0; ngr = 0;
    for (int i = 0; i < 15; i++) begin
      sample();
      if ((bus.f_grant || bus.c_grant) && ngr < 5) begin
        seq = {seq[3:0], bus.f_grant};
        ngr++;
      end
      tick();
    end
    chk("d3_grant_count", ngr, 5);
    chk("d3_grant_order", seq, 5'b00010);
    clear_inputs();
    sample(); tick();

    // redirect while a fetch waits behind a busy cache
    bus.f_req_valid = 1; bus.f_index = 8'h44;
    sample(); tick();
    bus.f_req_valid = 0; bus.ic_busy = 1;
    for (int i = 0; i < 4; i++) begin sample(); tick(); end
    bus.ic_busy = 0;
    sample(); tick();
    bus.redirect = 1;
    sample(); tick();
    bus.redirect = 0;
    sample(); tick();
    bus.ic_resp_valid = 1;
    sample();
    chk("d4_discard",    bus.f_resp_discard, 1);
    chk("d4_resp_valid", bus.f_resp_valid,   0);
    tick();
    bus.ic_resp_valid = 0;
    sample(); tick();

    // watchdog expiry on a cache op, then normal service
    bus.c_req_valid = 1; bus.c_op = 2'b10; bus.c_index = 8'h55;
    sample(); tick();
    bus.c_req_valid = 0;
    sample(); tick();
    wcnt = 0; wat = -1;
    for (int i = 0; i < WDOG_MAX; i++) begin
      sample();
      if (bus.wdog_err) begin wcnt++; wat = i; end
      tick();
    end
    chk("d5_wdog_pulses", wcnt, 1);
    chk("d5_wdog_cycle",  wat,  WDOG_MAX - 1);
    bus.f_req_valid = 1; bus.f_index = 8'h66;
    sample(); chk("d5_idle_after", bus.arb_busy, 0); tick();
    bus.f_req_valid = 0;
    sample(); tick();
    bus.ic_resp_valid = 1;
    sample(); chk("d5_next_resp", bus.f_resp_valid, 1); tick();
    bus.ic_resp_valid = 0;
    sample(); tick();

    // reset while in REQ abandons the transaction
    bus.c_req_valid = 1; bus.c_op = 2'b01;
    sample(); tick();
    bus.c_req_valid = 0;
    #2 reset = 1'b0;
    #1;
    chk("d6_ic_valid", bus.ic_valid, 0);
    chk("d6_arb_busy", bus.arb_busy, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.ic_resp_valid = 1;
    for (int i = 0; i < 3; i++) begin
      sample(); chk("d6_no_done", bus.c_done, 0); tick();
    end
    clear_inputs();

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      bus.f_req_valid   = ($urandom_range(0, 9) < 6);
      bus.f_index       = 8'($urandom);
      bus.f_tag         = 20'($urandom);
      bus.f_offset      = 4'($urandom);
      bus.c_req_valid   = ($urandom_range(0, 9) < 4);
      bus.c_op          = 2'($urandom_range(0, 2));
      bus.c_index       = 8'($urandom);
      bus.c_tag         = 20'($urandom);
      bus.redirect      = ($urandom_range(0, 99) < 15);
      bus.ic_busy       = ($urandom_range(0, 9) < 4);
      bus.ic_resp_valid = ($urandom_range(0, 9) < 4);
      sample(); tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
